// File: rtl/text_console_buffer.sv
// Screen character store between the UART byte stream and the VGA text generator.
// Handles printable bytes, CR/LF/BS/FF and scrolls by rotating a physical row offset.
module text_console_buffer #(
  parameter int          COLS  = 32,
  parameter int          ROWS  = 4,
  parameter logic [7:0]  BLANK = 8'h20,
  localparam int         CW    = $clog2(COLS),
  localparam int         RW    = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_char,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic [RW-1:0] top_row,
  output logic [1:0]    dbg_state
);

  // Handshake: a byte transfers on every rising edge where in_valid and in_ready are
  // both high; in_ready depends only on the FSM state, never on in_valid.

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  localparam int              AW      = RW + CW;
  localparam int              DEPTH   = ROWS << CW;
  localparam logic [CW-1:0]   COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0]   ROW_MAX = RW'(ROWS - 1);
  localparam logic [7:0]      CH_BS   = 8'h08;
  localparam logic [7:0]      CH_LF   = 8'h0A;
  localparam logic [7:0]      CH_FF   = 8'h0C;
  localparam logic [7:0]      CH_CR   = 8'h0D;

  state_e        state_q;
  logic          ready_q;
  logic [RW-1:0] cur_row_q;
  logic [CW-1:0] cur_col_q;
  logic [RW-1:0] top_row_q;
  logic [RW-1:0] clr_row_q;
  logic [CW-1:0] clr_col_q;
  logic [7:0]    rd_char_q;

  // Cells are addressed as {physical row, column}; columns past COLS-1 stay unused.
  logic [7:0]    mem_q [0:DEPTH-1];

  logic          accept;
  logic          is_print;
  logic          nl_req;
  logic [RW-1:0] cur_phys_row;
  logic [RW-1:0] rd_phys_row;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [7:0]    wr_data_d;

  assign accept       = ready_q & in_valid;
  assign is_print     = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign nl_req       = accept & ((in_data == CH_LF) | (is_print & (cur_col_q == COL_MAX)));
  assign cur_phys_row = cur_row_q + top_row_q;
  assign rd_phys_row  = rd_row + top_row_q;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = {clr_row_q, clr_col_q};
    wr_data_d = BLANK;
    case (state_q)
      CLR_ALL, CLR_LINE: wr_en_d = 1'b1;
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cur_phys_row, cur_col_q};
            wr_data_d = in_data;
          end else if ((in_data == CH_BS) && (cur_col_q != '0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cur_phys_row, cur_col_q - CW'(1)};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
  end

  // Non-blocking write above gives read-before-write on a same-cell collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_char_q <= 8'h00;
    else       rd_char_q <= mem_q[{rd_phys_row, rd_col}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLR_ALL;
      ready_q   <= 1'b0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      top_row_q <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
    end else begin
      case (state_q)
        CLR_ALL: begin
          if (clr_col_q == COL_MAX) begin
            clr_col_q <= '0;
            if (clr_row_q == ROW_MAX) begin
              clr_row_q <= '0;
              state_q   <= IDLE;
              ready_q   <= 1'b1;
            end else begin
              clr_row_q <= clr_row_q + RW'(1);
            end
          end else begin
            clr_col_q <= clr_col_q + CW'(1);
          end
        end
        CLR_LINE: begin
          if (clr_col_q == COL_MAX) begin
            clr_col_q <= '0;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
          end else begin
            clr_col_q <= clr_col_q + CW'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              if (cur_col_q < COL_MAX) cur_col_q <= cur_col_q + CW'(1);
              else                     cur_col_q <= '0;
            end else if (in_data == CH_CR) begin
              cur_col_q <= '0;
            end else if (in_data == CH_BS) begin
              if (cur_col_q != '0) cur_col_q <= cur_col_q - CW'(1);
            end else if (in_data == CH_FF) begin
              cur_row_q <= '0;
              cur_col_q <= '0;
              top_row_q <= '0;
              clr_row_q <= '0;
              clr_col_q <= '0;
              state_q   <= CLR_ALL;
              ready_q   <= 1'b0;
            end
            // On the bottom row, the old logical row 0 becomes the new bottom and is blanked.
            if (nl_req) begin
              if (cur_row_q < ROW_MAX) begin
                cur_row_q <= cur_row_q + RW'(1);
              end else begin
                top_row_q <= top_row_q + RW'(1);
                clr_row_q <= top_row_q;
                clr_col_q <= '0;
                state_q   <= CLR_LINE;
                ready_q   <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= CLR_ALL;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign rd_char   = rd_char_q;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;
  assign top_row   = top_row_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_text_console_buffer.sv
// Directed bench for text_console_buffer (COLS=32, ROWS=4): reset clear, printing,
// wrap, scroll, control codes and reset during a line clear.
module tb_text_console_buffer;

  localparam int COLS = 32;
  localparam int ROWS = 4;
  localparam int RW   = 2;
  localparam int CW   = 5;

  logic          clk;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [7:0]    rd_char;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] top_row;
  logic [1:0]    dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  text_console_buffer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_char   (rd_char),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .top_row   (top_row),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cur(input string tag, input int r, input int c);
    chk({tag, "_row"}, 32'(cur_row), 32'(r));
    chk({tag, "_col"}, 32'(cur_col), 32'(c));
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic wait_ready(input int max_cycles);
    int n = 0;
    while (!in_ready && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready(300);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b);
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    while (!in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_cell(input int r, input int c, output logic [7:0] d);
    rd_row = RW'(r);
    rd_col = CW'(c);
    @(negedge clk);
    d = rd_char;
  endtask

  task automatic chk_cell(input string tag, input int r, input int c, input logic [7:0] exp);
    logic [7:0] d;
    rd_cell(r, c, d);
    chk(tag, 32'(d), 32'(exp));
  endtask

  task automatic chk_row(input string tag, input int r, input logic [7:0] exp);
    for (int c = 0; c < COLS; c++) chk_cell(tag, r, c, exp);
  endtask

  task automatic chk_blank_screen(input string tag);
    for (int r = 0; r < ROWS; r++) chk_row(tag, r, 8'h20);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_row   = '0;
    rd_col   = '0;
    repeat (3) @(negedge clk);

    // 1. reset state and power-up clear
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_rd_char", 32'(rd_char), 32'h00);
    chk("rst_top", 32'(top_row), 32'd0);
    chk_cur("rst_cur", 0, 0);
    reset = 1'b0;
    busy_cycles(n);
    chk("rst_clear_cycles", 32'(n), 32'd128);
    chk_blank_screen("rst_blank");
    chk_cur("rst_cur_after", 0, 0);

    // 2. printable bytes and read latency
    send_byte(8'h41);
    send_byte(8'h42);
    chk_cur("ab_cur", 0, 2);
    rd_row = 2'd0;
    rd_col = 5'd0;
    @(negedge clk);
    chk("lat_a", 32'(rd_char), 32'h41);
    rd_col = 5'd1;
    @(negedge clk);
    chk("lat_b", 32'(rd_char), 32'h42);

    // held valid for two cycles is two bytes
    wait_ready(10);
    in_data  = 8'h68;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk_cur("held_cur", 0, 4);
    chk_cell("held_c2", 0, 2, 8'h68);
    chk_cell("held_c3", 0, 3, 8'h68);
    chk_cell("held_c4", 0, 4, 8'h20);

    // 3. line wrap from home
    send_byte(8'h0D);
    chk_cur("cr_home", 0, 0);
    send_n(8'h78, 33);
    chk_row("wrap_row0", 0, 8'h78);
    chk_cell("wrap_r1c0", 1, 0, 8'h78);
    chk_cell("wrap_r1c1", 1, 1, 8'h20);
    chk_cur("wrap_cur", 1, 1);
    chk("wrap_top", 32'(top_row), 32'd0);

    // 4. scroll
    send_byte(8'h0C);
    busy_cycles(n);
    chk("ff1_cycles", 32'(n), 32'd128);
    chk_cur("ff1_cur", 0, 0);
    send_n(8'h30, 32);
    send_n(8'h31, 32);
    send_n(8'h32, 32);
    send_n(8'h33, 31);
    send_byte(8'h0D);
    send_n(8'h33, 5);
    chk_cur("fill_cur", 3, 5);
    chk("fill_top", 32'(top_row), 32'd0);
    send_byte(8'h0A);
    chk("scroll_top", 32'(top_row), 32'd1);
    chk_cur("scroll_cur_busy", 3, 5);
    busy_cycles(n);
    chk("scroll_cycles", 32'(n), 32'd32);
    chk_row("scroll_row0", 0, 8'h31);
    chk_row("scroll_row1", 1, 8'h32);
    chk_cell("scroll_r2c0", 2, 0, 8'h33);
    chk_cell("scroll_r2c30", 2, 30, 8'h33);
    chk_cell("scroll_r2c31", 2, 31, 8'h20);
    chk_row("scroll_row3", 3, 8'h20);
    chk_cur("scroll_cur", 3, 5);

    // 5. control codes
    send_byte(8'h51);
    chk_cell("q_cell", 3, 5, 8'h51);
    chk_cur("q_cur", 3, 6);
    send_byte(8'h08);
    chk_cur("bs_cur", 3, 5);
    chk_cell("bs_cell", 3, 5, 8'h20);
    chk_cell("bs_above", 2, 5, 8'h33);
    send_byte(8'h07);
    chk_cur("bel_cur", 3, 5);
    chk("bel_top", 32'(top_row), 32'd1);
    chk("bel_ready", 32'(in_ready), 32'd1);
    send_byte(8'h0D);
    chk_cur("cr_cur", 3, 0);
    send_byte(8'h0C);
    busy_cycles(n);
    chk("ff2_cycles", 32'(n), 32'd128);
    chk_cur("ff2_cur", 0, 0);
    chk("ff2_top", 32'(top_row), 32'd0);
    chk_blank_screen("ff2_blank");
    send_byte(8'h0A);
    chk_cur("lf_keep_col", 1, 0);
    send_n(8'h6B, 32);
    chk_cur("bs0_pre", 2, 0);
    send_byte(8'h08);
    chk_cur("bs0_cur", 2, 0);
    chk_cell("bs0_prev_row", 1, 31, 8'h6B);
    chk_cell("bs0_cell", 2, 0, 8'h20);

    // 6. reset during a line clear
    send_byte(8'h6D);
    chk_cell("m_cell", 2, 0, 8'h6D);
    send_byte(8'h0A);
    send_byte(8'h0A);
    chk("mid_top", 32'(top_row), 32'd1);
    repeat (9) @(negedge clk);
    chk("mid_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_top", 32'(top_row), 32'd0);
    chk("mid_rst_rd", 32'(rd_char), 32'h00);
    chk_cur("mid_rst_cur", 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_cycles(n);
    chk("mid_clear_cycles", 32'(n), 32'd128);
    chk_blank_screen("mid_blank");
    chk_cur("mid_cur", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
